// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Purpose  : Iterative multiply/divide unit with architectural HI/LO.
//             MULT uses a radix-2 shift-add, DIV a radix-2 restoring divide.
//             Each takes 32 RUN cycles plus one PREP cycle and one FIX cycle.
//             MTHI/MTLO write HI/LO directly and never make the unit busy.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start, op          - request; op 00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//             op_signed          - signed MULT/DIV operands
//             src_a, src_b       - operands / MTHI-MTLO data
//             flush              - abort an in-flight MULT/DIV
//             busy, done         - operation in progress / one-cycle completion
//             stall_req          - pipeline stall request (combinational)
//             div_by_zero        - pulse alongside done for a zero divisor
//             hi, lo             - architectural HI/LO registers
//  Config   : MDU_SIGNED_EN defined   -> op_signed is honoured.
//             MDU_SIGNED_EN undefined -> all operations unsigned, FIX passes
//                                        results through unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        op_signed,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic        stall_req,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] C_OP_MTHI = 2'b10;
   localparam logic [1:0] C_OP_MTLO = 2'b11;
   localparam logic [4:0] C_LAST_ITER = 5'd31;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;          // multiplicand / dividend (magnitude after PREP)
   logic [31:0] b_q, b_d;          // multiplier / divisor   (magnitude after PREP)
   logic [63:0] acc_q, acc_d;      // MULT: {partial hi, multiplier}; DIV: {rem, quotient}
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        sgn_q, sgn_d;
   logic        neg_res_q, neg_res_d;  // negate product / quotient
   logic        neg_rem_q, neg_rem_d;  // negate remainder
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        w_op_signed;
   logic        w_accept;
   logic        w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic        w_div_ge;
   logic [31:0] w_div_diff;
   logic [63:0] w_div_next;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

`ifdef MDU_SIGNED_EN
   assign w_op_signed = op_signed;
`else
   // Signed support is compiled out; the input is deliberately left unused.
   logic w_unused_op_signed;
   assign w_unused_op_signed = op_signed;
   assign w_op_signed        = 1'b0;
`endif

   // Requests are only taken when no MULT/DIV is in flight.
   assign w_accept  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign stall_req = busy_q | (w_accept & ~op[1]);

   // Operand magnitudes; sgn_q is zero in the unsigned build so these pass through.
   assign w_a_neg = sgn_q & a_q[31];
   assign w_b_neg = sgn_q & b_q[31];
   assign w_a_mag = w_a_neg ? (~a_q + 32'd1) : a_q;
   assign w_b_mag = w_b_neg ? (~b_q + 32'd1) : b_q;

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole 65-bit result right by one.
   assign w_mul_sum  = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, a_q})
                                : {1'b0, acc_q[63:32]};
   assign w_mul_next = {w_mul_sum, acc_q[31:1]};

   // Restoring step: the shifted partial remainder is acc_q[63:31] (33 bits).
   // When it is >= divisor the true difference fits in 32 bits.
   assign w_div_ge   = acc_q[63:31] >= {1'b0, b_q};
   assign w_div_diff = acc_q[62:31] - b_q;
   assign w_div_next = {(w_div_ge ? w_div_diff : acc_q[62:31]), acc_q[30:0], w_div_ge};

   // Sign correction applied on the FIX -> DONE transition.
   assign w_prod_fix = neg_res_q ? (~acc_q + 64'd1)          : acc_q;
   assign w_quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1)    : acc_q[31:0];
   assign w_rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1)   : acc_q[63:32];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      sgn_d     = sgn_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (w_accept) begin
               if (op == C_OP_MTHI) begin
                  hi_d = src_a;
               end else if (op == C_OP_MTLO) begin
                  lo_d = src_a;
               end else begin
                  a_d      = src_a;
                  b_d      = src_b;
                  is_div_d = op[0];
                  sgn_d    = w_op_signed;
                  state_d  = S_PREP;
               end
            end
         end

         S_PREP: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (is_div_q && (b_q == 32'd0)) begin
               // Zero divisor: finish immediately, HI/LO untouched.
               state_d = S_DONE;
               done_d  = 1'b1;
               dbz_d   = 1'b1;
            end else begin
               a_d       = w_a_mag;
               b_d       = w_b_mag;
               neg_res_d = w_a_neg ^ w_b_neg;
               neg_rem_d = is_div_q & w_a_neg;
               acc_d     = {32'd0, (is_div_q ? w_a_mag : w_b_mag)};
               cnt_d     = 5'd0;
               state_d   = S_RUN;
            end
         end

         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? w_div_next : w_mul_next;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == C_LAST_ITER) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               if (is_div_q) begin
                  lo_d = w_quot_fix;
                  hi_d = w_rem_fix;
               end else begin
                  hi_d = w_prod_fix[63:32];
                  lo_d = w_prod_fix[31:0];
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         acc_q     <= 64'd0;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         sgn_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         sgn_q     <= sgn_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have a single clock domain; the reset is synchronous and active-high.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide port: start  input  1  request, sampled on clk.
REQ-005 SHALL provide port: op  input  2  operation: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 SHALL provide port: op_signed  input  1  1 = signed MULT/DIV operands.
REQ-007 SHALL provide port: src_a  input  32  multiplicand, dividend, or MTHI/MTLO data.
REQ-008 SHALL provide port: src_b  input  32  multiplier or divisor.
REQ-009 SHALL provide port: flush  input  1  abort an in-flight MULT/DIV.
REQ-010 SHALL provide port: busy  output  1  MULT/DIV in progress.
REQ-011 SHALL provide port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port: stall_req  output  1  pipeline stall request.
REQ-013 SHALL provide port: div_by_zero  output  1  one-cycle pulse, concurrent with done.
REQ-014 SHALL provide ports: hi  output  32  and  lo  output  32  architectural HI/LO registers.

Function
REQ-015 SHALL implement a state machine with states IDLE, PREP, RUN, FIX, DONE.
REQ-016 SHALL accept start only in IDLE or DONE, and SHALL ignore start in PREP, RUN and FIX with no state change.
REQ-017 SHALL, for MTHI/MTLO accepted, write src_a into hi/lo at that clock edge, remain in or return to IDLE, and assert neither busy nor done.
REQ-018 SHALL, for MULT/DIV accepted, latch the operands and op, and enter PREP.
REQ-019 SHALL, in PREP, form operand magnitudes and result signs, then enter RUN with a 5-bit iteration counter at 0.
REQ-020 SHALL, in PREP, go directly to DONE with div_by_zero=1 and hi/lo unchanged when a DIV has divisor 0.
REQ-021 SHALL, in RUN, perform one radix-2 step per cycle: shift-add for MULT, restoring subtract for DIV; RUN lasts 32 cycles and the counter wrap 31->0 moves the FSM to FIX.
REQ-022 SHALL, in FIX, apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
REQ-023 SHALL, on entry to DONE, load hi/lo (MULT: hi=product[63:32], lo=product[31:0]; DIV: lo=quotient, hi=remainder) and assert done for exactly that one DONE cycle.
REQ-024 SHALL, with an accept at edge E0, hold PREP in cycle 1, RUN in cycles 2-33, FIX in cycle 34, and DONE with done=1 in cycle 35; a divide by zero gives DONE in cycle 2.
REQ-025 SHALL leave DONE for IDLE unless a new start is accepted in the same cycle.
REQ-026 SHALL drive busy=1 in PREP, RUN and FIX.
REQ-027 SHALL drive stall_req = busy OR (start AND op[1]==0 AND state is IDLE or DONE), combinationally.
REQ-028 SHALL produce a signed DIV result of lo=0x80000000, hi=0 for 0x80000000 / 0xFFFFFFFF, with no exception.
REQ-029 SHALL, on flush in PREP/RUN/FIX, return to IDLE at the next edge with hi/lo unchanged and no done; flush takes priority over start in the same cycle; flush in IDLE/DONE has no effect.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and clear the counter and working registers.
REQ-031 SHALL abort any operation when rst is asserted mid-operation, with no done pulse; rst has priority over flush and start.

Configuration
REQ-032 SHALL, with macro MDU_SIGNED_EN defined, honour op_signed as in REQ-019/REQ-022.
REQ-033 SHALL, without MDU_SIGNED_EN, ignore op_signed, treat all operations as unsigned, and make FIX a pass-through, with latency unchanged.

Verification
REQ-034 SHALL be verified by: reset, then MULT signed 0xFFFFFFFE x 0x00000003 -> done at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=1 in cycles 1-34.
REQ-035 SHALL be verified by: DIV signed -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned 100 / 7 -> lo=14, hi=2.
REQ-036 SHALL be verified by: DIV 5 / 0 -> done and div_by_zero high in cycle 2, hi/lo keep prior values.
REQ-037 SHALL be verified by: MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0, done=0; a start issued during RUN -> ignored.
REQ-038 SHALL be verified by: MULT started, flush asserted in cycle 10 -> IDLE at cycle 11, no done, hi/lo unchanged; rst asserted in cycle 20 of a second op -> all outputs 0.
REQ-039 SHALL be verified by: back-to-back MULT with start asserted in the DONE cycle -> second op accepted, its done arriving 35 cycles later.
